// File: rtl/div_16x8_seq_pkg.sv
// Shared constants for the 16/8 sequential restoring divider.
package div_16x8_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_t;

    // Quotient reported for both divide-by-zero and quotient overflow
    localparam logic [7:0] ErrQuot = 8'hFF;
    localparam logic [7:0] OvfRem  = 8'h00;

endpackage

// File: rtl/div_16x8_seq_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_16x8_seq_step (
    input  logic [8:0] p,
    input  logic       bit_in,
    input  logic [7:0] divisor,
    output logic [8:0] p_next,
    output logic       qbit
);

    logic [8:0] t;

    always_comb begin
        t      = {p[7:0], bit_in};
        qbit   = (t >= {1'b0, divisor});
        p_next = qbit ? (t - {1'b0, divisor}) : t;
    end

endmodule

// File: rtl/div_16x8_seq.sv
// 16-bit by 8-bit sequential restoring divider with valid/ready handshakes and
// an optional mode that skips the last APPROX_LSB quotient iterations.
module div_16x8_seq
    import div_16x8_seq_pkg::*;
#(
    parameter int unsigned APPROX_LSB = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [7:0]  B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  Q,
    output logic [7:0]  R,
    output logic        err
);

    localparam int unsigned N = 8 - APPROX_LSB;

    state_t     state;
    logic [8:0] p;
    logic [7:0] s;
    logic [7:0] b_q;
    logic [7:0] qacc;
    logic [3:0] cnt;

    logic [8:0] p_next;
    logic       qbit;
    logic [7:0] q_next;
    logic [7:0] q_final;

    div_16x8_seq_step u_step (
        .p       (p),
        .bit_in  (s[7]),
        .divisor (b_q),
        .p_next  (p_next),
        .qbit    (qbit)
    );

    // Only N bits are produced; the skipped LSBs end up as zeros after the shift
    always_comb begin
        q_next  = {qacc[6:0], qbit};
        q_final = q_next << APPROX_LSB;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Q         <= 8'h00;
            R         <= 8'h00;
            err       <= 1'b0;
            p         <= 9'h000;
            s         <= 8'h00;
            b_q       <= 8'h00;
            qacc      <= 8'h00;
            cnt       <= 4'd0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        b_q      <= B;
                        in_ready <= 1'b0;
                        if (B == 8'h00) begin
                            Q         <= ErrQuot;
                            R         <= A[7:0];
                            err       <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= StDone;
                        end else if (A[15:8] >= B) begin
                            Q         <= ErrQuot;
                            R         <= OvfRem;
                            err       <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= StDone;
                        end else begin
                            p     <= {1'b0, A[15:8]};
                            s     <= A[7:0];
                            qacc  <= 8'h00;
                            cnt   <= 4'd0;
                            err   <= 1'b0;
                            state <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    p    <= p_next;
                    s    <= {s[6:0], 1'b0};
                    qacc <= q_next;
                    cnt  <= cnt + 4'd1;
                    if (cnt == 4'(N - 1)) begin
                        Q         <= q_final;
                        R         <= p_next[7:0];
                        out_valid <= 1'b1;
                        state     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= StIdle;
                end
            endcase
        end
    end

endmodule
